// File: rtl/bp_table.sv
// bp_table: direct-mapped, tagged table of 2-bit saturating branch counters.
// A combinational guess port serves fetch/decode. A registered check port
// trains or allocates the indexed entry once execute resolves the branch.

// SatCounter2: the core's 2-bit saturating up/down next-state stage.
// Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
module SatCounter2 (
   input  logic [1:0] i_count,
   input  logic       i_up,
   input  logic       i_dn,
   output logic [1:0] o_next
);

   // Step the counter one position in the requested direction, clamping at
   // both ends; conflicting or absent requests hold the value.
   always_comb begin
      o_next = i_count;
      if (i_up && !i_dn && (i_count != 2'b11)) begin
         o_next = i_count + 2'd1;
      end else if (i_dn && !i_up && (i_count != 2'b00)) begin
         o_next = i_count - 2'd1;
      end
   end

endmodule

module bp_table #(
   parameter int PC_WIDTH = 32,
   parameter int LINES    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PC_WIDTH-1:0] pc_guess,
   input  logic                is_br_guess,
   output logic                hit_guess,
   output logic                taken_guess,
   input  logic [PC_WIDTH-1:0] pc_check,
   input  logic                is_br_check,
   input  logic                br_taken_check
);

   localparam int IDX   = $clog2(LINES);
   localparam int TAG_W = PC_WIDTH - IDX - 2;

   // Per-entry storage: valid bit, tag and 2-bit counter.
   logic [LINES-1:0] r_valid;
   logic [TAG_W-1:0] r_tag [LINES];
   logic [1:0]       r_ctr [LINES];

   // Guess-side field split and lookup.
   logic [IDX-1:0]   w_guessIdx;
   logic [TAG_W-1:0] w_guessTag;
   logic             w_guessHit;

   // Check-side field split, lookup and counter next-state.
   logic [IDX-1:0]   w_checkIdx;
   logic [TAG_W-1:0] w_checkTag;
   logic             w_checkHit;
   logic [1:0]       w_checkCtr;
   logic [1:0]       w_satNext;
   logic [1:0]       w_allocCtr;

   // The low two PC bits never select anything: instructions are word aligned.
   logic w_unused;
   assign w_unused = ^{pc_guess[1:0], pc_check[1:0]};

   assign w_guessIdx = pc_guess[IDX+1:2];
   assign w_guessTag = pc_guess[PC_WIDTH-1:IDX+2];
   assign w_checkIdx = pc_check[IDX+1:2];
   assign w_checkTag = pc_check[PC_WIDTH-1:IDX+2];

   // Guess lookup reads the stored state directly, so a same-cycle check
   // write is not visible until the following cycle.
   always_comb begin
      w_guessHit  = is_br_guess && r_valid[w_guessIdx] &&
                    (r_tag[w_guessIdx] == w_guessTag);
      hit_guess   = w_guessHit;
      taken_guess = w_guessHit && r_ctr[w_guessIdx][1];
   end

   // Check-side read decides between training an existing entry and
   // allocating over whatever currently occupies the line.
   always_comb begin
      w_checkHit = r_valid[w_checkIdx] && (r_tag[w_checkIdx] == w_checkTag);
      w_checkCtr = r_ctr[w_checkIdx];
      w_allocCtr = br_taken_check ? 2'b10 : 2'b01;
   end

   SatCounter2 u_satCounter (
      .i_count (w_checkCtr),
      .i_up    (br_taken_check),
      .i_dn    (~br_taken_check),
      .o_next  (w_satNext)
   );

   // Single write port: reset wipes the whole table (dropping any check in
   // the same cycle); otherwise a resolved branch trains or allocates its line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < LINES; i++) begin
            r_tag[i] <= '0;
            r_ctr[i] <= 2'b01;
         end
      end else if (is_br_check) begin
         if (w_checkHit) begin
            r_ctr[w_checkIdx] <= w_satNext;
         end else begin
            r_valid[w_checkIdx] <= 1'b1;
            r_tag[w_checkIdx]   <= w_checkTag;
            r_ctr[w_checkIdx]   <= w_allocCtr;
         end
      end
   end

endmodule

// File: tb/tb_bp_table.sv
// tb_bp_table: directed table-driven checks of bp_table plus hand-written
// multi-cycle sequences for aliasing, same-cycle access and reset.
`timescale 1ns/1ps

module tb_bp_table;

   logic        clk;
   logic        rst;
   logic [31:0] pc_guess;
   logic        is_br_guess;
   logic        hit_guess;
   logic        taken_guess;
   logic [31:0] pc_check;
   logic        is_br_check;
   logic        br_taken_check;

   int total;
   int bad;

   typedef struct {
      logic        rst;
      logic        isCheck;
      logic [31:0] pcCheck;
      logic        takenCheck;
      logic        isGuess;
      logic [31:0] pcGuess;
      logic        doCompare;
      logic        expHit;
      logic        expTaken;
      string       name;
   } vector_t;

   vector_t vecs[$];

   bp_table #(.PC_WIDTH(32), .LINES(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_guess       (pc_guess),
      .is_br_guess    (is_br_guess),
      .hit_guess      (hit_guess),
      .taken_guess    (taken_guess),
      .pc_check       (pc_check),
      .is_br_check    (is_br_check),
      .br_taken_check (br_taken_check)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare the guess outputs against the expected values for this cycle.
   task automatic checkOutput(input string name, input logic expHit, input logic expTaken);
      total++;
      if (hit_guess !== expHit) begin
         bad++;
         $display("[TB] FAIL %s hit_guess got=%b want=%b", name, hit_guess, expHit);
      end
      total++;
      if (taken_guess !== expTaken) begin
         bad++;
         $display("[TB] FAIL %s taken_guess got=%b want=%b", name, taken_guess, expTaken);
      end
   endtask

   // Drive one cycle of inputs after the falling edge, check the combinational
   // guess a little later, and let the next rising edge commit any check.
   task automatic applyStimulus(input vector_t v);
      @(negedge clk);
      rst            = v.rst;
      is_br_check    = v.isCheck;
      pc_check       = v.pcCheck;
      br_taken_check = v.takenCheck;
      is_br_guess    = v.isGuess;
      pc_guess       = v.pcGuess;
      #1;
      if (v.doCompare) checkOutput(v.name, v.expHit, v.expTaken);
      @(posedge clk);
   endtask

   function automatic vector_t mk(input logic r, input logic ic, input logic [31:0] pcC,
                                  input logic tc, input logic ig, input logic [31:0] pcG,
                                  input logic cmp, input logic eh, input logic et,
                                  input string nm);
      vector_t v;
      v.rst = r; v.isCheck = ic; v.pcCheck = pcC; v.takenCheck = tc;
      v.isGuess = ig; v.pcGuess = pcG; v.doCompare = cmp;
      v.expHit = eh; v.expTaken = et; v.name = nm;
      return v;
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b0; is_br_check = 1'b0; pc_check = '0; br_taken_check = 1'b0;
      is_br_guess = 1'b0; pc_guess = '0;

      // Main table: reset, allocate, train up, saturate, train down, qualifiers.
      vecs.push_back(mk(1, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, "reset"));
      vecs.push_back(mk(0, 0, 32'h0,    0, 1, 32'h1000, 1, 0, 0, "postReset1000"));
      vecs.push_back(mk(0, 0, 32'h0,    0, 1, 32'h0,    1, 0, 0, "postReset0"));
      vecs.push_back(mk(0, 1, 32'h1000, 1, 1, 32'h1000, 1, 0, 0, "allocSameCycle"));
      vecs.push_back(mk(0, 1, 32'h1000, 1, 1, 32'h1000, 1, 1, 1, "ctr10"));
      vecs.push_back(mk(0, 1, 32'h1000, 1, 1, 32'h1000, 1, 1, 1, "ctr11a"));
      vecs.push_back(mk(0, 1, 32'h1000, 1, 1, 32'h1000, 1, 1, 1, "ctr11b"));
      vecs.push_back(mk(0, 0, 32'h0,    0, 1, 32'h1000, 1, 1, 1, "ctr11sat"));
      vecs.push_back(mk(0, 1, 32'h1000, 0, 1, 32'h1000, 1, 1, 1, "ntFrom11"));
      vecs.push_back(mk(0, 0, 32'h0,    0, 1, 32'h1000, 1, 1, 1, "ctr10after"));
      vecs.push_back(mk(0, 1, 32'h1000, 1, 1, 32'h1003, 1, 1, 1, "backTo11"));
      vecs.push_back(mk(0, 1, 32'h1000, 0, 1, 32'h1000, 1, 1, 1, "down11"));
      vecs.push_back(mk(0, 1, 32'h1000, 0, 1, 32'h1000, 1, 1, 1, "down10"));
      vecs.push_back(mk(0, 1, 32'h1000, 0, 1, 32'h1000, 1, 1, 0, "down01"));
      vecs.push_back(mk(0, 1, 32'h1000, 0, 1, 32'h1000, 1, 1, 0, "down00"));
      vecs.push_back(mk(0, 0, 32'h0,    0, 1, 32'h1000, 1, 1, 0, "down00sat"));
      vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h1000, 1, 0, 0, "noGuessQual"));
      vecs.push_back(mk(0, 0, 32'h0,    0, 1, 32'h8000_1000, 1, 0, 0, "highTagMiss"));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(0, 0, 32'h1000, logic'(i % 2 == 0), 1, 32'h1000, 1, 1, 0, "noCheckHold"));
      vecs.push_back(mk(0, 1, 32'h1000, 1, 1, 32'h1000, 1, 1, 0, "upFrom00"));
      vecs.push_back(mk(0, 1, 32'h1000, 1, 1, 32'h1000, 1, 1, 0, "ctr01"));
      vecs.push_back(mk(0, 0, 32'h0,    0, 1, 32'h1000, 1, 1, 1, "ctr10again"));

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // Alias eviction: 0x1000 and 0x1080 share index 0 with different tags.
      applyStimulus(mk(1, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, "aliasReset"));
      applyStimulus(mk(0, 1, 32'h1000, 1, 0, 32'h0,    0, 0, 0, "aliasAlloc"));
      applyStimulus(mk(0, 1, 32'h1080, 0, 1, 32'h1000, 1, 1, 1, "aliasPreEvict"));
      applyStimulus(mk(0, 0, 32'h0,    0, 1, 32'h1000, 1, 0, 0, "aliasEvicted"));
      applyStimulus(mk(0, 0, 32'h0,    0, 1, 32'h1080, 1, 1, 0, "aliasNewOwner"));

      // Same-cycle guess and check: guess sees old 01, next cycle sees 10.
      applyStimulus(mk(0, 1, 32'h1080, 1, 1, 32'h1080, 1, 1, 0, "sameCycleOld"));
      applyStimulus(mk(0, 0, 32'h0,    0, 1, 32'h1080, 1, 1, 1, "sameCycleNew"));

      // Check in the reset cycle is dropped and the whole table is invalidated.
      applyStimulus(mk(1, 1, 32'h2004, 1, 0, 32'h0,    0, 0, 0, "resetWithCheck"));
      applyStimulus(mk(0, 0, 32'h0,    0, 1, 32'h2004, 1, 0, 0, "droppedCheck"));
      applyStimulus(mk(0, 0, 32'h0,    0, 1, 32'h1080, 1, 0, 0, "fullInvalidate"));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Bound the run in case the clock or a task stalls.
   initial begin
      #100000;
      $display("[TB] FAIL timeout got=running want=finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] timeout");
   end

endmodule
